// File: rtl/pixel_row_packer.sv
// pixel_row_packer
//   Assembles a serial stream of PIX_W-bit pixels (valid/ready) into rows of
//   PIXELS pixels, pixel i at row bits [(i+1)*PIX_W-1 : i*PIX_W]. A one-row
//   output register decouples assembly from downstream back-pressure.
//
//   Optional build macro: PACKER_FLUSH_EN adds in_last, which closes a short
//   row early and zero-fills its unwritten slots.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous discard of the partially assembled / pending row
//   in_pixel   incoming pixel
//   in_valid   in_pixel is valid
//   in_ready   packer accepts in_pixel this cycle
//   row_data   assembled row, pixel 0 in the LSBs
//   row_valid  row_data holds a complete row
//   row_ready  downstream takes row_data this cycle
//   in_last    (PACKER_FLUSH_EN only) final pixel of a short row
//
// State | meaning
// ------+--------------------------------------------------------------
// FILL  | accepting pixels into the assembly buffer
// FULL  | complete row in the buffer, waiting for the output register
module pixel_row_packer #(
  parameter int PIXELS = 64,
  parameter int PIX_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [PIX_W-1:0]        in_pixel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [PIXELS*PIX_W-1:0] row_data,
  output logic                    row_valid,
  input  logic                    row_ready
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                    in_last
`endif
);

  localparam int CNT_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int ROW_W = PIXELS * PIX_W;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PIXELS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [ROW_W-1:0]   buf_q;
  logic [ROW_W-1:0]   fill_row;
  logic               accept;
  logic               out_free;
  logic               close_row;
  logic               last_w;
  logic               load_fill;
  logic               load_buf;

`ifdef PACKER_FLUSH_EN
  assign last_w = in_last;
`else
  assign last_w = 1'b0;
`endif

  // in_ready is held low while reset is asserted so no beat is accepted
  // before the packer leaves reset.
  assign in_ready  = rst_n && (state_q == FILL) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_free  = !row_valid || row_ready;
  assign close_row = accept && ((count_q == LAST_SLOT) || last_w);

  // Buffer with the current pixel merged into slot count. When the row is
  // closed early, slots above count are zeroed rather than left stale.
  always_comb begin
    fill_row = buf_q;
    for (int i = 0; i < PIXELS; i++) begin
      if (i == int'(count_q)) begin
        fill_row[i*PIX_W +: PIX_W] = in_pixel;
      end else if ((i > int'(count_q)) && last_w) begin
        fill_row[i*PIX_W +: PIX_W] = '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load_fill = 1'b0;
    load_buf  = 1'b0;
    case (state_q)
      FILL: begin
        if (close_row) begin
          if (out_free) load_fill = 1'b1;
          else          state_d   = FULL;
        end
      end
      FULL: begin
        if (clear) begin
          state_d = FILL;
        end else if (out_free) begin
          load_buf = 1'b1;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      buf_q     <= '0;
      row_data  <= '0;
      row_valid <= 1'b0;
    end else begin
      if (clear) begin
        count_q <= '0;
      end else if (accept) begin
        count_q <= close_row ? '0 : count_q + CNT_W'(1);
      end

      if (accept) buf_q <= fill_row;

      if (load_fill) begin
        row_data  <= fill_row;
        row_valid <= 1'b1;
      end else if (load_buf) begin
        row_data  <= buf_q;
        row_valid <= 1'b1;
      end else if (row_ready) begin
        row_valid <= 1'b0;
      end
    end
  end

endmodule
